pc_fetch_unit: RTL

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Front-end PC generator: sequential / JAL / branch-JALR next-PC selection with
// stall handling, redirects deferred while stalled, flush, misalignment flag and redirect count.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      jal_target,
  input  logic [31:0]      alu_target,
  input  logic             stall,
  output logic [31:0]      imem_addr,
  output logic             imem_en,
  output logic [31:0]      fetch_pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL      = 2'd1,
    STALL_PEND = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_target, pend_d;
  logic            req;
  logic [XLEN-1:0] target;
  logic            redirect_c;
  logic [XLEN-1:0] applied_target_c;

  // Redirect request decode; pc_sel 11 behaves as sequential.
  always_comb begin
    req    = (pc_sel == 2'b01) || (pc_sel == 2'b10);
    target = (pc_sel == 2'b01) ? jal_target : alu_target;
    target[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pend_target <= '0;
    end else begin
      state_q     <= state_d;
      pend_target <= pend_d;
    end
  end

  // Next state: a request seen while stalled is parked, newest request wins.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_target;
    case (state_q)
      RUN: begin
        if (stall) begin
          if (req) begin
            state_d = STALL_PEND;
            pend_d  = target;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        if (stall) begin
          if (req) begin
            state_d = STALL_PEND;
            pend_d  = target;
          end
        end else begin
          state_d = RUN;
        end
      end
      STALL_PEND: begin
        if (stall) begin
          if (req) pend_d = target;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Redirect decision: a parked target is applied on stall release unless a fresh request overrides it.
  always_comb begin
    redirect_c       = 1'b0;
    applied_target_c = target;
    case (state_q)
      RUN, STALL: redirect_c = ~stall & req;
      STALL_PEND: begin
        redirect_c       = ~stall;
        applied_target_c = req ? target : pend_target;
      end
      default: redirect_c = 1'b0;
    endcase
  end

  assign imem_addr = pc_q;
  assign imem_en   = rst_n & ~stall;
  assign flush     = rst_n & redirect_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      fetch_pc     <= '0;
      fetch_valid  <= 1'b0;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
    end else if (!stall) begin
      fetch_pc    <= pc_q;
      fetch_valid <= ~redirect_c;
      if (redirect_c) begin
        pc_q         <= applied_target_c;
        redirect_cnt <= redirect_cnt + CNT_W'(1);
        if (applied_target_c[1]) misalign <= 1'b1;
      end else begin
        pc_q <= pc_q + XLEN'(4);
      end
    end
  end

endmodule
